// File: rtl/fitbit_pkg.sv
// rtl/fitbit_pkg.sv - page and scheduler state types shared by the display page scheduler
package fitbit_pkg;

  localparam int MAX_PAGES = 4;

  typedef enum logic [1:0] {STEPS, DISTANCE, OVER_THRESH, HIGH_ACT} page_t;

  typedef enum logic [1:0] {ROTATE, HOLDING, BLANKED} sched_state_t;

  // Next page in rotation order, wrapping after the last populated page.
  function automatic page_t next_page(input page_t p, input logic [2:0] num_pages);
    logic [2:0] n;
    n = {1'b0, p} + 3'd1;
    return (n >= num_pages) ? STEPS : page_t'(n[1:0]);
  endfunction

endpackage

// File: rtl/display_page_scheduler_tick_edge_detect.sv
// rtl/display_page_scheduler_tick_edge_detect.sv - one-cycle event on each rising edge of the tick level
module tick_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic TICK_TOGGLE,
  output logic EVENT
);

  logic tick_d;

  always_ff @(posedge CLK) begin
    if (RESET) tick_d <= 1'b0;
    else       tick_d <= TICK_TOGGLE;
  end

  assign EVENT = TICK_TOGGLE & ~tick_d;

endmodule

// File: rtl/display_page_scheduler.sv
// rtl/display_page_scheduler.sv - auto-rotating display page selector with hold and page-jump requests
// Optional idle blanking is enabled by defining DISPLAY_AUTO_BLANK_EN.
module display_page_scheduler
  import fitbit_pkg::*;
#(
  parameter int NUM_PAGES   = 4,
  parameter int DWELL_TICKS = 1,
  parameter int BLANK_TICKS = 15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK_TOGGLE,
  input  logic       HOLD,
  input  logic       REQ_VALID,
  input  logic [1:0] REQ_PAGE,
  output logic [1:0] PAGE,
  output logic       PAGE_CHANGE,
  output logic       REQ_ERR,
  output logic       BLANK
);

  localparam logic [2:0] NUM_P      = 3'(NUM_PAGES);
  localparam logic [3:0] DWELL_LAST = 4'(DWELL_TICKS - 1);

  if (NUM_PAGES < 2 || NUM_PAGES > MAX_PAGES || DWELL_TICKS < 1 || DWELL_TICKS > 15 ||
      BLANK_TICKS < 1 || BLANK_TICKS > 255) begin : g_bad_param
    $error("display_page_scheduler: parameter out of range");
  end

  sched_state_t state;
  page_t        page_q;
  logic [3:0]   dwell;
  logic         tick_event;
  logic         req_ok;
  logic         blank_hit;

  tick_edge_detect u_tick (
    .CLK         (CLK),
    .RESET       (RESET),
    .TICK_TOGGLE (TICK_TOGGLE),
    .EVENT       (tick_event)
  );

  assign req_ok = ({1'b0, REQ_PAGE} < NUM_P);
  assign PAGE   = page_q;

`ifdef DISPLAY_AUTO_BLANK_EN
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_TICKS - 1);
  logic [7:0] idle;
  logic       hold_d;
  logic       counted;

  // Only events that leave the state alone count toward blanking.
  assign counted   = tick_event && !REQ_VALID &&
                     ((state == ROTATE && !HOLD) || (state == HOLDING && HOLD));
  assign blank_hit = tick_event && (idle == BLANK_LAST);
`else
  assign blank_hit = 1'b0;
  assign BLANK     = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ROTATE;
      page_q      <= STEPS;
      dwell       <= '0;
      PAGE_CHANGE <= 1'b0;
      REQ_ERR     <= 1'b0;
`ifdef DISPLAY_AUTO_BLANK_EN
      idle        <= '0;
      hold_d      <= 1'b0;
      BLANK       <= 1'b0;
`endif
    end else begin
      PAGE_CHANGE <= 1'b0;
      REQ_ERR     <= 1'b0;
`ifdef DISPLAY_AUTO_BLANK_EN
      hold_d      <= HOLD;
`endif
      if (REQ_VALID && !req_ok) begin
        REQ_ERR <= 1'b1;
      end else if (REQ_VALID) begin
        // A request beats a same-cycle tick event; the event is dropped.
        page_q      <= page_t'(REQ_PAGE);
        PAGE_CHANGE <= (REQ_PAGE != page_q);
        dwell       <= '0;
        if (state == BLANKED) state <= HOLD ? HOLDING : ROTATE;
`ifdef DISPLAY_AUTO_BLANK_EN
        idle  <= '0;
        BLANK <= 1'b0;
`endif
      end else begin
        case (state)
          ROTATE: begin
            if (HOLD) begin
              state <= HOLDING;
            end else if (tick_event && !blank_hit) begin
              if (dwell == DWELL_LAST) begin
                page_q      <= next_page(page_q, NUM_P);
                PAGE_CHANGE <= 1'b1;
                dwell       <= '0;
              end else begin
                dwell <= dwell + 4'd1;
              end
            end
          end
          HOLDING: begin
            if (!HOLD) begin
              state <= ROTATE;
              dwell <= '0;
            end
          end
          default: begin
`ifdef DISPLAY_AUTO_BLANK_EN
            if (HOLD && !hold_d) begin
              state <= HOLDING;
              BLANK <= 1'b0;
              idle  <= '0;
            end
`else
            state <= ROTATE;
`endif
          end
        endcase
`ifdef DISPLAY_AUTO_BLANK_EN
        if (counted) begin
          idle <= idle + 8'd1;
          if (blank_hit) begin
            state <= BLANKED;
            BLANK <= 1'b1;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_display_page_scheduler.sv
// tb/tb_display_page_scheduler.sv - randomized bench against a rule-level scheduler model
module tb_display_page_scheduler;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       hold;
  logic       rv;
  logic [1:0] rp;
  logic [1:0] page_a, page_b, page_c;
  logic       pc_a, pc_b, pc_c;
  logic       err_a, err_b, err_c;
  logic       blank_a, blank_b, blank_c;

  int checks = 0;
  int errors = 0;
  int pc_a_cnt = 0;

`ifdef DISPLAY_AUTO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam int S_ROT = 0, S_HOLD = 1, S_BLANK = 2;

  typedef struct {
    int page; int dwell; int idle; int st;
    int pc; int err; int blank; int tick_d; int hold_d;
  } mdl_t;

  mdl_t ma, mb, mc;

  display_page_scheduler #(.NUM_PAGES(4), .DWELL_TICKS(1), .BLANK_TICKS(15)) u_dut_a (
    .CLK(clk), .RESET(rst), .TICK_TOGGLE(tick), .HOLD(hold), .REQ_VALID(rv), .REQ_PAGE(rp),
    .PAGE(page_a), .PAGE_CHANGE(pc_a), .REQ_ERR(err_a), .BLANK(blank_a));

  display_page_scheduler #(.NUM_PAGES(3), .DWELL_TICKS(2), .BLANK_TICKS(15)) u_dut_b (
    .CLK(clk), .RESET(rst), .TICK_TOGGLE(tick), .HOLD(hold), .REQ_VALID(rv), .REQ_PAGE(rp),
    .PAGE(page_b), .PAGE_CHANGE(pc_b), .REQ_ERR(err_b), .BLANK(blank_b));

  display_page_scheduler #(.NUM_PAGES(4), .DWELL_TICKS(1), .BLANK_TICKS(2)) u_dut_c (
    .CLK(clk), .RESET(rst), .TICK_TOGGLE(tick), .HOLD(hold), .REQ_VALID(rv), .REQ_PAGE(rp),
    .PAGE(page_c), .PAGE_CHANGE(pc_c), .REQ_ERR(err_c), .BLANK(blank_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of scheduler behaviour, stated as rules over pages, dwell and idle counts.
  function automatic mdl_t model(input mdl_t m, input int np, input int dw, input int bt,
                                 input bit r, input bit tk, input bit hd, input bit v, input int p);
    mdl_t n;
    bit   ev;
    n = m;
    ev = tk && (m.tick_d == 0);
    n.tick_d = tk;
    n.hold_d = hd;
    n.pc = 0;
    n.err = 0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (v && p >= np) begin
      n.err = 1;
    end else if (v) begin
      n.page = p; n.dwell = 0; n.idle = 0;
      if (m.st == S_BLANK) begin n.st = hd ? S_HOLD : S_ROT; n.blank = 0; end
    end else if (m.st == S_BLANK) begin
      if (hd && m.hold_d == 0) begin n.st = S_HOLD; n.blank = 0; n.idle = 0; end
    end else if (m.st == S_ROT && hd) begin
      n.st = S_HOLD;
    end else if (m.st == S_HOLD && !hd) begin
      n.st = S_ROT; n.dwell = 0;
    end else if (ev) begin
      if (BLANK_EN && m.idle + 1 >= bt) begin
        n.st = S_BLANK; n.blank = 1; n.idle = m.idle + 1;
      end else begin
        n.idle = BLANK_EN ? m.idle + 1 : 0;
        if (m.st == S_ROT) begin
          if (m.dwell + 1 >= dw) begin n.page = (m.page + 1) % np; n.dwell = 0; end
          else n.dwell = m.dwell + 1;
        end
      end
    end
    n.pc = (n.page != m.page) ? 1 : 0;
    return n;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    ma = model(ma, 4, 1, 15, rst, tick, hold, rv, int'(rp));
    mb = model(mb, 3, 2, 15, rst, tick, hold, rv, int'(rp));
    mc = model(mc, 4, 1, 2, rst, tick, hold, rv, int'(rp));
    @(posedge clk);
    #1;
    chk("a_page", page_a, ma.page);   chk("a_chg", pc_a, ma.pc);
    chk("a_err", err_a, ma.err);      chk("a_blank", blank_a, ma.blank);
    chk("b_page", page_b, mb.page);   chk("b_chg", pc_b, mb.pc);
    chk("b_err", err_b, mb.err);      chk("b_blank", blank_b, mb.blank);
    chk("c_page", page_c, mc.page);   chk("c_chg", pc_c, mc.pc);
    chk("c_err", err_c, mc.err);      chk("c_blank", blank_c, mc.blank);
    pc_a_cnt += int'(pc_a);
  endtask

  task automatic request(input logic [1:0] p);
    rv = 1'b1; rp = p;
    step();
    rv = 1'b0;
  endtask

  initial begin
    int saved;
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
    rst = 1'b1; tick = 1'b0; hold = 1'b0; rv = 1'b0; rp = 2'd0;
    step();
    rst = 1'b0;
    chk("rst_page", page_a, 0);
    chk("rst_blank", blank_a, 0);

    // Rotation through all pages with a tick toggle every 10 cycles.
    pc_a_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (i % 10 == 0) tick = ~tick;
      step();
    end
    chk("rot_pulses", pc_a_cnt, 4);
    chk("rot_wrap", page_a, 0);

    // Hold freezes the page across three events, then one event advances it.
    saved = int'(page_a);
    hold = 1'b1;
    pc_a_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) tick = ~tick;
      step();
    end
    chk("hold_pulses", pc_a_cnt, 0);
    chk("hold_page", page_a, saved);
    hold = 1'b0;
    step(); step();
    for (int i = 0; i < 20; i++) begin
      if (i % 10 == 0) tick = ~tick;
      step();
    end
    chk("unhold_adv", page_a, (saved + 1) % 4);

    // Request and event in the same cycle: request wins, dwell restarts.
    request(2'd0);
    tick = 1'b1;
    request(2'd2);
    chk("req_wins", page_a, 2);
    tick = 1'b0; step();
    tick = 1'b1; step();
    chk("after_req_evt", page_a, 3);

    // Out-of-range request on the three-page instance, then wrap 2 -> 0.
    saved = int'(page_b);
    request(2'd3);
    chk("b_err_pulse", err_b, 1);
    chk("b_err_page", page_b, saved);
    chk("a_no_err", err_a, 0);
    request(2'd2);
    for (int i = 0; i < 4; i++) begin
      tick = ~tick;
      step();
    end
    chk("b_wrap", page_b, 0);

    // Reset mid-dwell returns to page 0 and the next event counts normally.
    request(2'd2);
    tick = 1'b0; step();
    tick = 1'b1; step();
    chk("pre_rst_a", page_a, 3);
    tick = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_page", page_a, 0);
    chk("mid_rst_blank", blank_a, 0);
    tick = 1'b1; step();
    chk("post_rst_evt", page_a, 1);

    // Two idle events blank the BLANK_TICKS=2 instance; a request wakes it.
    tick = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick = ~tick;
      step();
    end
    chk("c_blanked", blank_c, BLANK_EN ? 1 : 0);
    request(2'd1);
    chk("c_wake_blank", blank_c, 0);
    chk("c_wake_page", page_c, 1);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(299) == 0);
      if ($urandom_range(3) == 0) tick = ~tick;
      if ($urandom_range(31) == 0) hold = ~hold;
      rv = ($urandom_range(11) == 0);
      rp = 2'($urandom_range(3));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
